// File: rtl/sprite_mover_if.sv
// ============================================================================
// Module      : sprite_mover_if
// Description : Control, pixel-stream and status bundle for sprite_mover.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sprite_mover_if;
    logic       en;
    logic       dir_right;
    logic       dir_down;
    logic       move_x;
    logic       move_y;
    logic [2:0] colour;
    logic       plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour_out;
    logic [7:0] x_ori;
    logic [6:0] y_ori;
    logic       busy;
    logic       done;

    modport master (
        output en, dir_right, dir_down, move_x, move_y, colour,
        input  plot, x, y, colour_out, x_ori, y_ori, busy, done
    );

    modport slave (
        input  en, dir_right, dir_down, move_x, move_y, colour,
        output plot, x, y, colour_out, x_ori, y_ori, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/sprite_mover.sv
// ============================================================================
// Module      : sprite_mover
// Description : Erases a rectangular sprite, moves its origin with wrap-around,
//               redraws it, then holds for a fixed number of cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_mover #(
    parameter int SPR_W    = 4,
    parameter int SPR_H    = 1,
    parameter int X0       = 60,
    parameter int Y0       = 91,
    parameter int STEP     = 1,
    parameter int XMAX     = 159,
    parameter int YMAX     = 119,
    parameter int HOLD_CYC = 16666
) (
    input  logic           clk,
    input  logic           reset,
    sprite_mover_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ERASE = 3'd1,
        S_MOVE  = 3'd2,
        S_DRAW  = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    localparam int              c_HW        = $clog2(HOLD_CYC) + 1;
    localparam logic [3:0]      c_COL_LAST  = 4'(SPR_W - 1);
    localparam logic [3:0]      c_ROW_LAST  = 4'(SPR_H - 1);
    localparam logic [c_HW-1:0] c_HOLD_LAST = c_HW'(HOLD_CYC - 1);
    localparam logic [8:0]      c_XLIM      = 9'(XMAX - SPR_W + 1);
    localparam logic [7:0]      c_YLIM      = 8'(YMAX - SPR_H + 1);
    localparam logic [8:0]      c_XSTEP     = 9'(STEP);
    localparam logic [7:0]      c_YSTEP     = 8'(STEP);

    state_t            r_state;
    logic [3:0]        r_col;
    logic [3:0]        r_row;
    logic [c_HW-1:0]   r_hold;
    logic [7:0]        r_x_ori;
    logic [6:0]        r_y_ori;
    logic [2:0]        r_colour;
    logic              r_dir_right;
    logic              r_dir_down;
    logic              r_move_x;
    logic              r_move_y;
    logic              r_plot;
    logic [7:0]        r_x;
    logic [6:0]        r_y;
    logic [2:0]        r_colour_out;
    logic              r_busy;
    logic              r_done;

    logic              w_last_col;
    logic              w_last_pix;
    logic [3:0]        w_ncol;
    logic [3:0]        w_nrow;
    logic [7:0]        w_px;
    logic [6:0]        w_py;
    logic [8:0]        w_x_right;
    logic [7:0]        w_y_down;
    logic [7:0]        w_nx;
    logic [6:0]        w_ny;

    assign w_last_col = (r_col == c_COL_LAST);
    assign w_last_pix = w_last_col && (r_row == c_ROW_LAST);
    assign w_ncol     = w_last_col ? 4'd0 : r_col + 4'd1;
    assign w_nrow     = w_last_col ? r_row + 4'd1 : r_row;
    assign w_px       = r_x_ori + {4'd0, w_ncol};
    assign w_py       = r_y_ori + {3'd0, w_nrow};

    // One extra bit so a step past the edge cannot alias back on-screen
    assign w_x_right  = {1'b0, r_x_ori} + c_XSTEP;
    assign w_y_down   = {1'b0, r_y_ori} + c_YSTEP;

    always_comb begin
        w_nx = r_x_ori;
        w_ny = r_y_ori;
        if (r_move_x) begin
            if (r_dir_right)
                w_nx = (w_x_right > c_XLIM) ? 8'd0 : w_x_right[7:0];
            else
                w_nx = ({1'b0, r_x_ori} < c_XSTEP) ? c_XLIM[7:0] : r_x_ori - c_XSTEP[7:0];
        end
        if (r_move_y) begin
            if (r_dir_down)
                w_ny = (w_y_down > c_YLIM) ? 7'd0 : w_y_down[6:0];
            else
                w_ny = ({1'b0, r_y_ori} < c_YSTEP) ? c_YLIM[6:0] : r_y_ori - c_YSTEP[6:0];
        end
    end

    // Outputs are registered: each branch loads what the next cycle presents
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_col        <= '0;
            r_row        <= '0;
            r_hold       <= '0;
            r_x_ori      <= 8'(X0);
            r_y_ori      <= 7'(Y0);
            r_colour     <= '0;
            r_dir_right  <= 1'b0;
            r_dir_down   <= 1'b0;
            r_move_x     <= 1'b0;
            r_move_y     <= 1'b0;
            r_plot       <= 1'b0;
            r_x          <= 8'(X0);
            r_y          <= 7'(Y0);
            r_colour_out <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.en) begin
                        r_state      <= S_ERASE;
                        r_colour     <= bus.colour;
                        r_dir_right  <= bus.dir_right;
                        r_dir_down   <= bus.dir_down;
                        r_move_x     <= bus.move_x;
                        r_move_y     <= bus.move_y;
                        r_col        <= '0;
                        r_row        <= '0;
                        r_plot       <= 1'b1;
                        r_x          <= r_x_ori;
                        r_y          <= r_y_ori;
                        r_colour_out <= '0;
                        r_busy       <= 1'b1;
                    end
                end
                S_ERASE, S_DRAW: begin
                    if (w_last_pix) begin
                        r_col        <= '0;
                        r_row        <= '0;
                        r_plot       <= 1'b0;
                        r_x          <= r_x_ori;
                        r_y          <= r_y_ori;
                        r_colour_out <= '0;
                        if (r_state == S_ERASE) begin
                            r_state <= S_MOVE;
                        end else begin
                            r_state <= S_HOLD;
                            r_hold  <= '0;
                            r_done  <= (HOLD_CYC == 1);
                        end
                    end else begin
                        r_col <= w_ncol;
                        r_row <= w_nrow;
                        r_x   <= w_px;
                        r_y   <= w_py;
                    end
                end
                S_MOVE: begin
                    r_state      <= S_DRAW;
                    r_x_ori      <= w_nx;
                    r_y_ori      <= w_ny;
                    r_col        <= '0;
                    r_row        <= '0;
                    r_plot       <= 1'b1;
                    r_x          <= w_nx;
                    r_y          <= w_ny;
                    r_colour_out <= r_colour;
                end
                S_HOLD: begin
                    if (r_hold == c_HOLD_LAST) begin
                        r_state <= S_IDLE;
                        r_hold  <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_hold <= r_hold + c_HW'(1);
                        r_done <= ((r_hold + c_HW'(1)) == c_HOLD_LAST);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_plot  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.plot       = r_plot;
    assign bus.x          = r_x;
    assign bus.y          = r_y;
    assign bus.colour_out = r_colour_out;
    assign bus.x_ori      = r_x_ori;
    assign bus.y_ori      = r_y_ori;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;

endmodule

`default_nettype wire

// File: tb/tb_sprite_mover.sv
// ============================================================================
// Module      : tb_sprite_mover
// Description : Scoreboard bench for sprite_mover over three parameter sets.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sprite_mover;

    logic clk;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    int   qa[$];
    int   qb[$];
    int   qc[$];

    sprite_mover_if ifa();
    sprite_mover_if ifb();
    sprite_mover_if ifc();

    // a: defaults with short hold; b: right-edge origin; c: 3x2 sprite, step 2
    sprite_mover #(.HOLD_CYC(4)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
    sprite_mover #(.X0(156), .Y0(50), .HOLD_CYC(2)) dut_b (.clk(clk), .reset(reset), .bus(ifb));
    sprite_mover #(.SPR_W(3), .SPR_H(2), .STEP(2), .HOLD_CYC(3)) dut_c (.clk(clk), .reset(reset), .bus(ifc));

    logic [2:0] done_v;
    logic [2:0] busy_v;
    assign done_v = {ifc.done, ifb.done, ifa.done};
    assign busy_v = {ifc.busy, ifb.busy, ifa.busy};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pk(input int p, input int d, input int x, input int y, input int c);
        return ((p & 1) << 19) | ((d & 1) << 18) | ((x & 255) << 10) | ((y & 127) << 3) | (c & 7);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push(input int d, input int v);
        case (d)
            0:       qa.push_back(v);
            1:       qb.push_back(v);
            default: qc.push_back(v);
        endcase
    endtask

    task automatic push_raster(input int d, input int ox, input int oy, input int w, input int h, input int c);
        for (int r = 0; r < h; r++)
            for (int k = 0; k < w; k++)
                push(d, pk(1, 0, ox + k, oy + r, c));
    endtask

    task automatic push_done(input int d, input int ox, input int oy);
        push(d, pk(0, 1, ox, oy, 0));
    endtask

    task automatic mon(input int d, input int act);
        int sz;
        int exp;
        exp = 0;
        case (d)
            0:       begin sz = qa.size(); if (sz > 0) exp = qa.pop_front(); end
            1:       begin sz = qb.size(); if (sz > 0) exp = qb.pop_front(); end
            default: begin sz = qc.size(); if (sz > 0) exp = qc.pop_front(); end
        endcase
        if (sz == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_out dut%0d actual=%0h required=none", d, act);
        end else begin
            chk($sformatf("out_dut%0d", d), act, exp);
        end
    endtask

    always @(negedge clk)
        if (!reset && (ifa.plot || ifa.done))
            mon(0, pk(int'(ifa.plot), int'(ifa.done), int'(ifa.x), int'(ifa.y), int'(ifa.colour_out)));
    always @(negedge clk)
        if (!reset && (ifb.plot || ifb.done))
            mon(1, pk(int'(ifb.plot), int'(ifb.done), int'(ifb.x), int'(ifb.y), int'(ifb.colour_out)));
    always @(negedge clk)
        if (!reset && (ifc.plot || ifc.done))
            mon(2, pk(int'(ifc.plot), int'(ifc.done), int'(ifc.x), int'(ifc.y), int'(ifc.colour_out)));

    task automatic drive(input int d, input logic [2:0] c, input logic dr, input logic dd,
                         input logic mx, input logic my);
        case (d)
            0:       begin ifa.colour = c; ifa.dir_right = dr; ifa.dir_down = dd; ifa.move_x = mx; ifa.move_y = my; end
            1:       begin ifb.colour = c; ifb.dir_right = dr; ifb.dir_down = dd; ifb.move_x = mx; ifb.move_y = my; end
            default: begin ifc.colour = c; ifc.dir_right = dr; ifc.dir_down = dd; ifc.move_x = mx; ifc.move_y = my; end
        endcase
    endtask

    task automatic set_en(input int d, input logic v);
        case (d)
            0:       ifa.en = v;
            1:       ifb.en = v;
            default: ifc.en = v;
        endcase
    endtask

    // Returns just after the accepting edge
    task automatic start_pass(input int d);
        @(negedge clk);
        set_en(d, 1'b1);
        @(posedge clk);
        #1;
        set_en(d, 1'b0);
    endtask

    task automatic wait_done(input int d, input int exp, input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done_v[d] && n < 200);
        chk(name, n, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        ifa.en = 1'b0; ifb.en = 1'b0; ifc.en = 1'b0;
        drive(0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(2, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_x_ori",  int'(ifa.x_ori), 60);
        chk("rst_y_ori",  int'(ifa.y_ori), 91);
        chk("rst_plot",   int'(ifa.plot), 0);
        chk("rst_busy",   int'(ifa.busy), 0);
        chk("rst_done",   int'(ifa.done), 0);
        chk("rst_colour", int'(ifa.colour_out), 0);

        // Pass 1: right/down, inputs scrambled right after acceptance
        push_raster(0, 60, 91, 4, 1, 0);
        push_raster(0, 61, 92, 4, 1, 5);
        push_done(0, 61, 92);
        drive(0, 3'd5, 1'b1, 1'b1, 1'b1, 1'b1);
        start_pass(0);
        drive(0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_done(0, 13, "lat_pass1");
        chk("p1_x_ori", int'(ifa.x_ori), 61);
        chk("p1_y_ori", int'(ifa.y_ori), 92);
        @(negedge clk);
        chk("p1_idle_busy", int'(ifa.busy), 0);

        // Pass 2: left/up, en raised during the done cycle must be ignored
        push_raster(0, 61, 92, 4, 1, 0);
        push_raster(0, 60, 91, 4, 1, 3);
        push_done(0, 60, 91);
        drive(0, 3'd3, 1'b0, 1'b0, 1'b1, 1'b1);
        start_pass(0);
        wait_done(0, 13, "lat_pass2");
        set_en(0, 1'b1);
        @(posedge clk);
        #1 set_en(0, 1'b0);
        @(negedge clk);
        chk("en_at_done_busy0", int'(ifa.busy), 0);
        @(negedge clk);
        chk("en_at_done_busy1", int'(ifa.busy), 0);

        // Passes 3/4: en held high gives back-to-back passes
        push_raster(0, 60, 91, 4, 1, 0);
        push_raster(0, 61, 91, 4, 1, 1);
        push_done(0, 61, 91);
        push_raster(0, 61, 91, 4, 1, 0);
        push_raster(0, 62, 91, 4, 1, 1);
        push_done(0, 62, 91);
        drive(0, 3'd1, 1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        set_en(0, 1'b1);
        @(posedge clk);
        #1;
        wait_done(0, 13, "lat_pass3");
        @(negedge clk);
        chk("b2b_idle_gap", int'(ifa.busy), 0);
        @(negedge clk);
        chk("b2b_restart", int'(ifa.busy), 1);
        set_en(0, 1'b0);
        wait_done(0, 12, "lat_pass4");
        chk("p4_x_ori", int'(ifa.x_ori), 62);
        chk("p4_y_ori", int'(ifa.y_ori), 91);

        // Pass 5: reset during the second DRAW pixel
        push_raster(0, 62, 91, 4, 1, 0);
        push(0, pk(1, 0, 63, 92, 6));
        drive(0, 3'd6, 1'b1, 1'b1, 1'b1, 1'b1);
        start_pass(0);
        repeat (6) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_plot",  int'(ifa.plot), 0);
        chk("mid_rst_busy",  int'(ifa.busy), 0);
        chk("mid_rst_x_ori", int'(ifa.x_ori), 60);
        chk("mid_rst_y_ori", int'(ifa.y_ori), 91);
        chk("mid_rst_qa",    qa.size(), 0);
        qa.delete();
        @(posedge clk);
        #1 reset = 1'b0;

        // Right-edge wrap and left wrap back
        push_raster(1, 156, 50, 4, 1, 0);
        push_raster(1, 0, 50, 4, 1, 7);
        push_done(1, 0, 50);
        drive(1, 3'd7, 1'b1, 1'b0, 1'b1, 1'b0);
        start_pass(1);
        wait_done(1, 11, "lat_wrap_r");
        chk("wrap_r_x_ori", int'(ifb.x_ori), 0);
        push_raster(1, 0, 50, 4, 1, 0);
        push_raster(1, 156, 50, 4, 1, 4);
        push_done(1, 156, 50);
        drive(1, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0);
        start_pass(1);
        wait_done(1, 11, "lat_wrap_l");
        chk("wrap_l_x_ori", int'(ifb.x_ori), 156);
        chk("wrap_l_y_ori", int'(ifb.y_ori), 50);

        // 3x2 sprite, step 2, y axis frozen
        push_raster(2, 60, 91, 3, 2, 0);
        push_raster(2, 62, 91, 3, 2, 5);
        push_done(2, 62, 91);
        drive(2, 3'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        start_pass(2);
        wait_done(2, 16, "lat_3x2");
        chk("c_x_ori", int'(ifc.x_ori), 62);
        chk("c_y_ori", int'(ifc.y_ori), 91);

        repeat (3) @(negedge clk);
        chk("busy_all_idle", int'(busy_v), 0);
        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);
        chk("qc_drained", qc.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sprite_mover.md
SPRITE_MOVER -- requirements
Module: sprite_mover

Interface
REQ-001 SHALL have parameter SPR_W, default 4, sprite width in pixels (1..16).
REQ-002 SHALL have parameter SPR_H, default 1, sprite height in pixels (1..16).
REQ-003 SHALL have parameters X0 / Y0, defaults 60 / 91, reset origin.
REQ-004 SHALL have parameter STEP, default 1, pixels moved per axis per move (1..7).
REQ-005 SHALL have parameters XMAX / YMAX, defaults 159 / 119, last visible column and row.
REQ-006 SHALL have parameter HOLD_CYC, default 16666, cycles held after draw (>=1).
REQ-007 SHALL have ports: clk  in  1  system clock, single clock domain; all state changes on its rising edge.
REQ-008 SHALL have ports: reset  in  1  synchronous, active-high.
REQ-009 SHALL have ports: en  in  1  start one erase/move/draw/hold pass; sampled in IDLE only.
REQ-010 SHALL have ports: dir_right, dir_down  in  1 each  direction, per axis.
REQ-011 SHALL have ports: move_x, move_y  in  1 each  per-axis motion enable (0 = axis frozen).
REQ-012 SHALL have ports: colour  in  3  sprite colour.
REQ-013 SHALL have ports: plot  out  1  pixel write strobe; x  out  8; y  out  7; colour_out  out  3.
REQ-014 SHALL have ports: x_ori  out  8, y_ori  out  7  current top-left origin.
REQ-015 SHALL have ports: busy  out  1  high outside IDLE; done  out  1  one-cycle end-of-pass pulse.

Function
REQ-016 SHALL implement FSM states IDLE, ERASE, MOVE, DRAW, HOLD.
REQ-017 SHALL go IDLE->ERASE on a cycle with en=1 in IDLE; en SHALL be ignored in all other states.
REQ-018 SHALL latch colour, dir_right, dir_down, move_x, move_y on the accepting cycle; later input changes SHALL NOT affect the pass.
REQ-019 ERASE: SHALL emit SPR_W*SPR_H pixels, one per cycle, row-major (x fastest), plot=1, colour_out=0, x=x_ori+col, y=y_ori+row.
REQ-020 SHALL go ERASE->MOVE after the last pixel; MOVE SHALL last exactly 1 cycle with plot=0.
REQ-021 MOVE: per enabled axis, origin SHALL change by +STEP (right/down) or -STEP (left/up); disabled axis unchanged.
REQ-022 Wrap-around, x: right move with x_ori+STEP > XMAX-SPR_W+1 SHALL set x_ori=0; left move with x_ori < STEP SHALL set x_ori=XMAX-SPR_W+1.
REQ-023 Wrap-around, y: same rule using YMAX and SPR_H; the sprite SHALL never be drawn partially off-screen.
REQ-024 Arithmetic SHALL be done 1 bit wider than the port, so no modulo-256/128 aliasing.
REQ-025 DRAW: SHALL emit the same raster as ERASE at the new origin with colour_out = latched colour, plot=1.
REQ-026 HOLD: SHALL count HOLD_CYC cycles with plot=0; done=1 in the final HOLD cycle; next state IDLE.
REQ-027 Pass latency SHALL be exactly 2*SPR_W*SPR_H+1+HOLD_CYC cycles from the cycle after acceptance to return to IDLE.
REQ-028 An en=1 in the same cycle done=1 SHALL be ignored; the earliest acceptance is the following IDLE cycle.
REQ-029 In IDLE/MOVE/HOLD: x=x_ori, y=y_ori, colour_out=0, plot=0.
REQ-030 Pixel and hold counters SHALL clear on every state entry.

Reset
REQ-031 reset=1 at a clock edge SHALL force: state IDLE, x_ori=X0, y_ori=Y0, plot=0, busy=0, done=0, colour_out=0, counters 0.
REQ-032 reset SHALL take priority over en and over any state, including mid-ERASE/DRAW/HOLD; no pixel SHALL be emitted in the cycle after reset.

Verification
REQ-033 SHALL verify defaults, HOLD_CYC=4: reset, en pulse, right/down, move both -> 4 erase pixels (60..63,91) colour 0, MOVE, 4 draw pixels (61..64,92), 4 hold, done at cycle 13.
REQ-034 SHALL verify right edge: origin forced to (156,50), SPR_W=4, right -> x_ori=0 after MOVE; left from x_ori=0 -> x_ori=156.
REQ-035 SHALL verify SPR_W=3, SPR_H=2, STEP=2, move_y=0 -> 6 pixels each phase in row-major order, y_ori unchanged, x_ori+2.
REQ-036 SHALL verify colour and direction changes mid-pass are ignored; en held high continuously -> back-to-back passes with one IDLE cycle between.
REQ-037 SHALL verify reset asserted mid-DRAW -> next cycle plot=0, busy=0, x_ori=60, y_ori=91.
REQ-038 SHALL verify en=1 coincident with done=1 is not accepted.
